// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mouse_pkg
// Brief   : Shared types, widths and the saturating coordinate update.
// Revision: 1.0 - initial release
// ============================================================================
package mouse_pkg;

    localparam int COORD_W = 10;
    localparam int DELTA_W = 11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_CALC  = 2'd2,
        S_APPLY = 2'd3
    } state_t;

    // Signed 12-bit add clamped to [0, maxv]; never wraps.
    function automatic logic [COORD_W-1:0] sat_add(
        input logic [COORD_W-1:0]     cur,
        input logic signed [DELTA_W:0] d,
        input logic [COORD_W-1:0]     maxv
    );
        logic signed [DELTA_W:0] sum;
        sum = $signed({2'b00, cur}) + d;
        if (sum < 0)
            return '0;
        if (sum > $signed({2'b00, maxv}))
            return maxv;
        return sum[COORD_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : toggle_sync_edge
// Brief   : 2-flop synchroniser for a toggle signal plus armed edge detect.
// Revision: 1.0 - initial release
// ============================================================================
module toggle_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tgl,
    output logic o_event
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [2:0] r_arm_sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prev   <= 1'b0;
            r_arm_sr <= 3'b000;
        end else begin
            r_sync1  <= i_tgl;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_arm_sr <= {r_arm_sr[1:0], 1'b1};
        end
    end

    // Arm only once the reset zeros have flushed through prev, so a toggle
    // line already high at reset never looks like an edge.
    assign o_event = (r_sync2 ^ r_prev) & r_arm_sr[2];

endmodule
`default_nettype wire

// File: rtl/mouse_cursor_tracker.sv
`default_nettype none
// ============================================================================
// Module  : mouse_cursor_tracker
// Brief   : Accumulates PS/2 mouse packets into a saturated cursor position.
//           Optional macro ACCEL_EN doubles post-shift magnitudes >= ACC_TH.
// Revision: 1.0 - initial release
// ============================================================================
module mouse_cursor_tracker
    import mouse_pkg::*;
#(
    parameter int H_MAX      = 639,
    parameter int V_MAX      = 479,
    parameter int X_INIT     = 320,
    parameter int Y_INIT     = 240,
    parameter int SENS_SHIFT = 0,
    parameter int ACC_TH     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_pkt_tgl,
    input  logic               i_click,
    input  logic               i_izquierda,
    input  logic               i_derecha,
    input  logic               i_arriba,
    input  logic               i_abajo,
    input  logic [7:0]         i_mag_x,
    input  logic [7:0]         i_mag_y,
    output logic [COORD_W-1:0] o_cur_x,
    output logic [COORD_W-1:0] o_cur_y,
    output logic               o_btn_held,
    output logic               o_btn_press,
    output logic               o_upd,
    output logic               o_busy
);

    localparam logic [COORD_W-1:0] c_H_MAX  = COORD_W'(H_MAX);
    localparam logic [COORD_W-1:0] c_V_MAX  = COORD_W'(V_MAX);
    localparam logic [COORD_W-1:0] c_X_INIT = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] c_Y_INIT = COORD_W'(Y_INIT);

    logic w_event;

    toggle_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_tgl   (i_pkt_tgl),
        .o_event (w_event)
    );

    state_t                  r_state;
    logic                    r_pending;
    logic                    r_click, r_izq, r_der, r_arr, r_aba;
    logic [7:0]              r_mag_x, r_mag_y;
    logic signed [DELTA_W:0] r_dx, r_dy;
    logic [COORD_W-1:0]      r_cur_x, r_cur_y;
    logic                    r_btn_held, r_btn_press, r_upd;

    logic [DELTA_W-1:0]      w_mag_x, w_mag_y;
    logic signed [DELTA_W:0] w_dx, w_dy;

    always_comb begin
        w_mag_x = {3'b000, r_mag_x} >> SENS_SHIFT;
        w_mag_y = {3'b000, r_mag_y} >> SENS_SHIFT;
`ifdef ACCEL_EN
        if (w_mag_x >= DELTA_W'(ACC_TH))
            w_mag_x = w_mag_x << 1;
        if (w_mag_y >= DELTA_W'(ACC_TH))
            w_mag_y = w_mag_y << 1;
`endif
        // Opposing or absent direction flags cancel the axis.
        w_dx = '0;
        if (r_izq && !r_der)
            w_dx = -$signed({1'b0, w_mag_x});
        else if (r_der && !r_izq)
            w_dx = $signed({1'b0, w_mag_x});
        w_dy = '0;
        if (r_arr && !r_aba)
            w_dy = -$signed({1'b0, w_mag_y});
        else if (r_aba && !r_arr)
            w_dy = $signed({1'b0, w_mag_y});
    end

`ifndef ACCEL_EN
    logic w_unused_acc_th;
    assign w_unused_acc_th = |DELTA_W'(ACC_TH);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pending   <= 1'b0;
            r_click     <= 1'b0;
            r_izq       <= 1'b0;
            r_der       <= 1'b0;
            r_arr       <= 1'b0;
            r_aba       <= 1'b0;
            r_mag_x     <= '0;
            r_mag_y     <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_cur_x     <= c_X_INIT;
            r_cur_y     <= c_Y_INIT;
            r_btn_held  <= 1'b0;
            r_btn_press <= 1'b0;
            r_upd       <= 1'b0;
        end else begin
            r_upd       <= 1'b0;
            r_btn_press <= 1'b0;
            if (w_event && r_state != S_IDLE)
                r_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_event || r_pending) begin
                        r_pending <= 1'b0;
                        r_state   <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_click <= i_click;
                    r_izq   <= i_izquierda;
                    r_der   <= i_derecha;
                    r_arr   <= i_arriba;
                    r_aba   <= i_abajo;
                    r_mag_x <= i_mag_x;
                    r_mag_y <= i_mag_y;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_dx    <= w_dx;
                    r_dy    <= w_dy;
                    r_state <= S_APPLY;
                end
                S_APPLY: begin
                    r_cur_x     <= sat_add(r_cur_x, r_dx, c_H_MAX);
                    r_cur_y     <= sat_add(r_cur_y, r_dy, c_V_MAX);
                    r_btn_held  <= r_click;
                    r_btn_press <= r_click & ~r_btn_held;
                    r_upd       <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cur_x     = r_cur_x;
    assign o_cur_y     = r_cur_y;
    assign o_btn_held  = r_btn_held;
    assign o_btn_press = r_btn_press;
    assign o_upd       = r_upd;
    assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mouse_cursor_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_mouse_cursor_tracker
// Brief   : Scoreboard bench: directed packets, queued expectations, monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mouse_cursor_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pkt_tgl = 1'b1;
    logic       click = 1'b0, izq = 1'b0, der = 1'b0, arr = 1'b0, aba = 1'b0;
    logic [7:0] mag_x = '0, mag_y = '0;

    logic [9:0] x1, y1, x2, y2;
    logic       held1, press1, upd1, busy1;
    logic       held2, press2, upd2, busy2;

    always #5 clk = ~clk;

    mouse_cursor_tracker u_dut (
        .clk(clk), .rst_n(rst_n), .i_pkt_tgl(pkt_tgl), .i_click(click),
        .i_izquierda(izq), .i_derecha(der), .i_arriba(arr), .i_abajo(aba),
        .i_mag_x(mag_x), .i_mag_y(mag_y), .o_cur_x(x1), .o_cur_y(y1),
        .o_btn_held(held1), .o_btn_press(press1), .o_upd(upd1), .o_busy(busy1)
    );

    // Second instance: sensitivity shift of 1, starting at X=100.
    mouse_cursor_tracker #(.SENS_SHIFT(1), .X_INIT(100)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .i_pkt_tgl(pkt_tgl), .i_click(click),
        .i_izquierda(izq), .i_derecha(der), .i_arriba(arr), .i_abajo(aba),
        .i_mag_x(mag_x), .i_mag_y(mag_y), .o_cur_x(x2), .o_cur_y(y2),
        .o_btn_held(held2), .o_btn_press(press2), .o_upd(upd2), .o_busy(busy2)
    );

    typedef struct {
        int x;
        int y;
        int held;
        int press;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   errors = 0;
    int   checks = 0;
    int   n_upd1 = 0;
    int   m_x = 100;
    int   m_y = 240;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int mstep(input int cur, input int mag, input bit neg,
                                 input bit pos, input int maxv);
        int d;
        int r;
        d = mag >> 1;
`ifdef ACCEL_EN
        if (d >= 16)
            d = d * 2;
`endif
        if (neg == pos)
            return cur;
        r = neg ? cur - d : cur + d;
        if (r < 0)
            r = 0;
        if (r > maxv)
            r = maxv;
        return r;
    endfunction

    // Monitor: pops an expectation on every Upd pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (upd1) begin
                n_upd1++;
                if (q1.size() == 0) begin
                    chk("unexpected_upd", 1, 0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("cur_x", int'(x1), e.x);
                    chk("cur_y", int'(y1), e.y);
                    chk("btn_held", int'(held1), e.held);
                    chk("btn_press", int'(press1), e.press);
                end
            end else if (press1) begin
                chk("press_without_upd", 1, 0);
            end
            if (upd2) begin
                if (q2.size() == 0) begin
                    chk("unexpected_upd_s", 1, 0);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    chk("shift_cur_x", int'(x2), e.x);
                    chk("shift_cur_y", int'(y2), e.y);
                end
            end
        end
    end

    task automatic push(input int ex, input int ey, input int eh, input int ep);
        exp_t e;
        e.x = ex; e.y = ey; e.held = eh; e.press = ep;
        q1.push_back(e);
        m_x = mstep(m_x, int'(mag_x), izq, der, 639);
        m_y = mstep(m_y, int'(mag_y), arr, aba, 479);
        e.x = m_x; e.y = m_y; e.held = 0; e.press = 0;
        q2.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            chk("upd_timeout", q1.size() + q2.size(), 0);
            q1.delete();
            q2.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic send(input bit c, input bit l, input bit r, input bit u,
                        input bit d, input int mx, input int my,
                        input int ex, input int ey, input int eh, input int ep);
        @(negedge clk);
        click = c; izq = l; der = r; arr = u; aba = d;
        mag_x = 8'(mx); mag_y = 8'(my);
        push(ex, ey, eh, ep);
        pkt_tgl = ~pkt_tgl;
        drain();
    endtask

    initial begin
        int base;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cur_x", int'(x1), 320);
        chk("rst_cur_y", int'(y1), 240);
        chk("rst_btn_held", int'(held1), 0);
        chk("rst_btn_press", int'(press1), 0);
        chk("rst_upd", int'(upd1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_shift_x", int'(x2), 100);
        repeat (20) @(negedge clk);
        chk("no_upd_after_reset", n_upd1, 0);

        //   clk L R U D  MX   MY   X    Y   H  P
        send(0, 0, 1, 0, 0,  40,   0, 360, 240, 0, 0);
        send(0, 0, 1, 0, 1,  10,   5, 370, 245, 0, 0);
        send(0, 1, 0, 0, 1, 255, 225, 115, 470, 0, 0);
        send(0, 1, 0, 0, 0, 110,  99,   5, 470, 0, 0);
        send(0, 1, 0, 0, 1, 200,  50,   0, 479, 0, 0);
        send(0, 1, 1, 1, 0,  50,  79,   0, 400, 0, 0);
        send(0, 0, 1, 1, 0, 255, 255, 255, 145, 0, 0);
        send(1, 0, 1, 1, 0, 255, 200, 510,   0, 1, 1);
        send(1, 0, 1, 1, 1, 255,   9, 639,   0, 1, 0);
        send(0, 0, 1, 0, 1,  10,   3, 639,   3, 0, 0);

        // Three toggles two cycles apart: the third folds into the pending one.
        @(negedge clk);
        click = 1; izq = 1; der = 0; arr = 0; aba = 0;
        mag_x = 8'd10; mag_y = 8'd0;
        base = n_upd1;
        push(629, 3, 1, 1);
        push(619, 3, 1, 0);
        pkt_tgl = ~pkt_tgl;
        repeat (2) @(negedge clk);
        pkt_tgl = ~pkt_tgl;
        repeat (2) @(negedge clk);
        pkt_tgl = ~pkt_tgl;
        drain();
        repeat (20) @(negedge clk);
        chk("triple_upd_count", n_upd1 - base, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
